// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for a small RISC-V subset. It steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module mc_sequencer #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    input  logic        zero_i,
    output logic [4:0]  ALUop_o,
    output logic        ALUSrc1,
    output logic        ALUSrc2,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCSrc,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] retire_cnt_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE, CL_R, CL_ADDI, CL_LW, CL_SW, CL_JALR, CL_BEQ
    } class_t;

    state_t      state_q, state_d;
    class_t      class_q, class_d;
    logic [4:0]  aluop_q, aluop_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    class_t      dec_class;
    logic [4:0]  dec_aluop;
    logic        retire;

    // An ALUop of zero from the decoder means the combination is not supported.
    always_comb begin
        dec_class = CL_NONE;
        dec_aluop = 5'b00000;
        case (opcode_i)
            7'b0110011: begin
                case ({funct7b5_i, funct3_i})
                    4'b0_000: dec_aluop = 5'b01101;
                    4'b1_000: dec_aluop = 5'b01110;
                    4'b0_001: dec_aluop = 5'b01000;
                    4'b0_100: dec_aluop = 5'b00110;
                    4'b0_101: dec_aluop = 5'b01001;
                    4'b0_110: dec_aluop = 5'b00101;
                    4'b0_111: dec_aluop = 5'b00100;
                    default:  dec_aluop = 5'b00000;
                endcase
                if (dec_aluop != 5'b00000) dec_class = CL_R;
            end
            7'b0010011: if (funct3_i == 3'b000) begin dec_class = CL_ADDI; dec_aluop = 5'b01100; end
            7'b0000011: if (funct3_i == 3'b010) begin dec_class = CL_LW;   dec_aluop = 5'b10100; end
            7'b0100011: if (funct3_i == 3'b010) begin dec_class = CL_SW;   dec_aluop = 5'b10101; end
            7'b1100111: if (funct3_i == 3'b000) begin dec_class = CL_JALR; dec_aluop = 5'b10100; end
            7'b1100011: if (funct3_i == 3'b000) begin dec_class = CL_BEQ;  dec_aluop = 5'b10001; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        aluop_d   = aluop_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        ALUop_o   = 5'b00000;
        ALUSrc1   = 1'b0;
        ALUSrc2   = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        PCSrc     = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ready_i) begin
                    IRWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_class == CL_NONE) begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    class_d = dec_class;
                    aluop_d = dec_aluop;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ALUop_o = aluop_q;
                case (class_q)
                    CL_R: state_d = WB;
                    CL_ADDI, CL_JALR: begin
                        ALUSrc2 = 1'b1;
                        state_d = WB;
                    end
                    CL_LW, CL_SW: begin
                        ALUSrc2 = 1'b1;
                        state_d = MEM;
                    end
                    CL_BEQ: begin
                        ALUSrc1 = 1'b1;
                        ALUSrc2 = 1'b1;
                        PCWrite = 1'b1;
                        PCSrc   = zero_i;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                ALUop_o  = aluop_q;
                ALUSrc2  = 1'b1;
                MemRead  = (class_q == CL_LW);
                MemWrite = (class_q == CL_SW);
                if (dmem_ready_i) begin
                    if (class_q == CL_LW) begin
                        state_d = WB;
                    end else begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = (class_q == CL_JALR);
                retire   = 1'b1;
                state_d  = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
        retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= state_t'(RESET_STATE);
            class_q      <= CL_NONE;
            aluop_q      <= 5'b00000;
            illegal_q    <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            class_q      <= class_d;
            aluop_q      <= aluop_d;
            illegal_q    <= illegal_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign state_o      = state_q;
    assign illegal_o    = illegal_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: walks each instruction class cycle by cycle
// and compares the packed control outputs with hand-computed values.
module tb_mc_sequencer;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        imemReady;
    logic        dmemReady;
    logic        zero;
    logic [4:0]  aluOp;
    logic        aluSrc1, aluSrc2, irWrite, pcWrite, memRead, memWrite, regWrite, pcSrc;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] retireCnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expRetire;
    logic [15:0] ctlObs;

    // Flag byte order: ALUSrc1 ALUSrc2 IRWrite PCWrite MemRead MemWrite RegWrite PCSrc
    assign ctlObs = {state, aluOp, aluSrc1, aluSrc2, irWrite, pcWrite,
                     memRead, memWrite, regWrite, pcSrc};

    mc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .imem_ready_i (imemReady),
        .dmem_ready_i (dmemReady),
        .zero_i       (zero),
        .ALUop_o      (aluOp),
        .ALUSrc1      (aluSrc1),
        .ALUSrc2      (aluSrc2),
        .IRWrite      (irWrite),
        .PCWrite      (pcWrite),
        .MemRead      (memRead),
        .MemWrite     (memWrite),
        .RegWrite     (regWrite),
        .PCSrc        (pcSrc),
        .state_o      (state),
        .illegal_o    (illegal),
        .retire_cnt_o (retireCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                                 input logic imem, input logic dmem);
        opcode    = op;
        funct3    = f3;
        funct7b5  = b5;
        imemReady = imem;
        dmemReady = dmem;
    endtask

    // Checks the current cycle's controls, then advances to the next negedge.
    task automatic expectCycle(input string tag, input logic [2:0] st, input logic [4:0] alu,
                               input logic [7:0] fl);
        #1;
        checkOutput(tag, {16'd0, ctlObs}, {16'd0, st, alu, fl});
        @(negedge clk);
    endtask

    task automatic runSimple(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic b5, input logic [4:0] alu,
                             input logic [7:0] execFl, input logic [7:0] wbFl);
        applyStimulus(op, f3, b5, 1'b1, 1'b1);
        expectCycle({tag, " fetch"}, 3'd0, 5'b00000, 8'b0010_0000);
        imemReady = 1'b0;
        expectCycle({tag, " decode"}, 3'd1, 5'b00000, 8'b0000_0000);
        expectCycle({tag, " exec"}, 3'd2, alu, execFl);
        expectCycle({tag, " wb"}, 3'd4, 5'b00000, wbFl);
        expRetire++;
        checkOutput({tag, " retire"}, retireCnt, expRetire);
    endtask

    logic [3:0] rFn  [7] = '{4'b0_000, 4'b1_000, 4'b0_001, 4'b0_100, 4'b0_101, 4'b0_110, 4'b0_111};
    logic [4:0] rAlu [7] = '{5'b01101, 5'b01110, 5'b01000, 5'b00110, 5'b01001, 5'b00101, 5'b00100};

    initial begin
        rst  = 1'b0;
        zero = 1'b0;
        expRetire = 32'd0;
        applyStimulus(7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("reset ctl", {16'd0, ctlObs}, 32'd0);
        checkOutput("reset illegal", {31'd0, illegal}, 32'd0);
        checkOutput("reset retire", retireCnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expectCycle("hold no imem 1", 3'd0, 5'b00000, 8'b0000_0000);
        expectCycle("hold no imem 2", 3'd0, 5'b00000, 8'b0000_0000);

        for (int i = 0; i < 7; i++)
            runSimple($sformatf("rtype%0d", i), 7'b0110011, rFn[i][2:0], rFn[i][3], rAlu[i],
                      8'b0000_0000, 8'b0001_0010);
        runSimple("addi", 7'b0010011, 3'b000, 1'b0, 5'b01100, 8'b0100_0000, 8'b0001_0010);
        runSimple("jalr", 7'b1100111, 3'b000, 1'b0, 5'b10100, 8'b0100_0000, 8'b0001_0011);

        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b1, 1'b0);
        expectCycle("lw fetch", 3'd0, 5'b00000, 8'b0010_0000);
        imemReady = 1'b0;
        expectCycle("lw decode", 3'd1, 5'b00000, 8'b0000_0000);
        expectCycle("lw exec", 3'd2, 5'b10100, 8'b0100_0000);
        for (int i = 0; i < 3; i++)
            expectCycle($sformatf("lw mem wait%0d", i), 3'd3, 5'b10100, 8'b0100_1000);
        dmemReady = 1'b1;
        expectCycle("lw mem done", 3'd3, 5'b10100, 8'b0100_1000);
        expectCycle("lw wb", 3'd4, 5'b00000, 8'b0001_0010);
        expRetire++;
        checkOutput("lw retire", retireCnt, expRetire);

        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
            expectCycle($sformatf("beq z%0d fetch", z), 3'd0, 5'b00000, 8'b0010_0000);
            imemReady = 1'b0;
            expectCycle($sformatf("beq z%0d decode", z), 3'd1, 5'b00000, 8'b0000_0000);
            expectCycle($sformatf("beq z%0d exec", z), 3'd2, 5'b10001, {7'b1101_000, z[0]});
            expRetire++;
            checkOutput($sformatf("beq z%0d retire", z), retireCnt, expRetire);
            expectCycle($sformatf("beq z%0d back to fetch", z), 3'd0, 5'b00000, 8'b0000_0000);
        end
        zero = 1'b0;

        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b1, 1'b1);
        expectCycle("sw fetch", 3'd0, 5'b00000, 8'b0010_0000);
        imemReady = 1'b0;
        expectCycle("sw decode", 3'd1, 5'b00000, 8'b0000_0000);
        expectCycle("sw exec", 3'd2, 5'b10101, 8'b0100_0000);
        expectCycle("sw mem done", 3'd3, 5'b10101, 8'b0101_0100);
        expRetire++;
        checkOutput("sw retire", retireCnt, expRetire);

        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b1, 1'b0);
        expectCycle("sw abort fetch", 3'd0, 5'b00000, 8'b0010_0000);
        imemReady = 1'b0;
        expectCycle("sw abort decode", 3'd1, 5'b00000, 8'b0000_0000);
        expectCycle("sw abort exec", 3'd2, 5'b10101, 8'b0100_0000);
        expectCycle("sw abort wait1", 3'd3, 5'b10101, 8'b0100_0100);
        #1;
        checkOutput("sw abort wait2", {16'd0, ctlObs}, {16'd0, 3'd3, 5'b10101, 8'b0100_0100});
        #2;
        rst = 1'b0;
        #1;
        checkOutput("sw abort ctl", {16'd0, ctlObs}, 32'd0);
        checkOutput("sw abort retire", retireCnt, 32'd0);
        expRetire = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        runSimple("add after abort", 7'b0110011, 3'b000, 1'b0, 5'b01101, 8'b0000_0000, 8'b0001_0010);

        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        checkOutput("preset retire", retireCnt, 32'hFFFF_FFFF);
        expRetire = 32'hFFFF_FFFF;
        runSimple("addi wrap", 7'b0010011, 3'b000, 1'b1, 5'b01100, 8'b0100_0000, 8'b0001_0010);

        applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b1, 1'b1);
        expectCycle("bad funct fetch", 3'd0, 5'b00000, 8'b0010_0000);
        expectCycle("bad funct decode", 3'd1, 5'b00000, 8'b0000_0000);
        expectCycle("bad funct trap", 3'd5, 5'b00000, 8'b0000_0000);
        checkOutput("bad funct illegal", {31'd0, illegal}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("trap reset illegal", {31'd0, illegal}, 32'd0);
        expRetire = 32'd0;
        @(negedge clk);
        rst = 1'b1;

        runSimple("add pre trap", 7'b0110011, 3'b000, 1'b0, 5'b01101, 8'b0000_0000, 8'b0001_0010);
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b1, 1'b1);
        expectCycle("trap fetch", 3'd0, 5'b00000, 8'b0010_0000);
        expectCycle("trap decode", 3'd1, 5'b00000, 8'b0000_0000);
        for (int i = 0; i < 10; i++) begin
            expectCycle($sformatf("trap hold%0d", i), 3'd5, 5'b00000, 8'b0000_0000);
            checkOutput($sformatf("trap illegal%0d", i), {31'd0, illegal}, 32'd1);
            checkOutput($sformatf("trap retire%0d", i), retireCnt, expRetire);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
